// File: rtl/exc_pkg.sv
// Shared definitions for exception/ERET pipeline recovery: sequencer states, vector offsets
// and ExcCode values used together with the CP0 exception logic.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_DRAIN    = 2'd3
    } exc_state_e;

    localparam logic [31:0] OFF_GEN    = 32'h0000_0180;
    localparam logic [31:0] OFF_REFILL = 32'h0000_0000;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_target_sel.sv
// Combinational redirect target selection (ERET -> EPC, else BEV base + vector offset).
// The refill vector is only honoured when TLB_REFILL_VEC_EN is defined.
module exc_target_sel
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_BASE_BEV1 = 32'hBFC0_0200,
    parameter logic [31:0] EXC_BASE_BEV0 = 32'h8000_0000
) (
    input  logic        take_eret,
    input  logic        refill,
    input  logic        bev,
    input  logic [31:0] epc,
    output logic [31:0] target
);

    logic [31:0] base_s;
    logic [31:0] off_s;

`ifdef TLB_REFILL_VEC_EN
    // Refill exceptions use the dedicated vector at offset zero.
    always_comb begin
        if (refill) begin
            off_s = OFF_REFILL;
        end else begin
            off_s = OFF_GEN;
        end
    end
`else
    logic unused_refill_s;
    assign unused_refill_s = refill;

    // Every exception uses the general vector.
    always_comb begin
        off_s = OFF_GEN;
    end
`endif

    // Final target mux: ERET returns to EPC, otherwise vector base plus offset.
    always_comb begin
        base_s = bev ? EXC_BASE_BEV1 : EXC_BASE_BEV0;
        if (take_eret) begin
            target = epc;
        end else begin
            target = base_s + off_s;
        end
    end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Pipeline recovery sequencer: accept exception/ERET, flush, hand redirect PC to fetch, drain.
// Optional feature macro: TLB_REFILL_VEC_EN (dedicated TLB refill vector).
module exc_redirect_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_VEC     = 32'hBFC0_0000,
    parameter logic [31:0] EXC_BASE_BEV1 = 32'hBFC0_0200,
    parameter logic [31:0] EXC_BASE_BEV0 = 32'h8000_0000,
    parameter int unsigned FLUSH_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic        exc_is_eret,
    input  logic        exc_refill,
    input  logic [31:0] epc_in,
    input  logic        status_bev,
    input  logic        stall_w,
    input  logic        redirect_ready,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        cp0_commit,
    output logic        busy,
    output logic [15:0] exc_cnt
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_e  state_r;
    logic [3:0]  flush_cnt_r;
    logic        flush_all_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;
    logic        cp0_commit_r;
    logic        busy_r;
    logic [15:0] exc_cnt_r;

    logic        take_eret_s;
    logic        refill_s;
    logic        accept_s;
    logic [31:0] target_s;

    // Exception has priority over a simultaneous ERET; acceptance only in IDLE when WB is not stalled.
    always_comb begin
        take_eret_s = exc_is_eret & ~exc_valid;
        refill_s    = exc_valid & exc_refill & ~exc_is_eret;
        accept_s    = (state_r == ST_IDLE) & (exc_valid | exc_is_eret) & ~stall_w;
    end

    exc_target_sel #(
        .EXC_BASE_BEV1 (EXC_BASE_BEV1),
        .EXC_BASE_BEV0 (EXC_BASE_BEV0)
    ) u_target_sel (
        .take_eret (take_eret_s),
        .refill    (refill_s),
        .bev       (status_bev),
        .epc       (epc_in),
        .target    (target_s)
    );

    // Recovery FSM with flush window counter, registered outputs and saturating exception count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_IDLE;
            flush_cnt_r      <= 4'd0;
            flush_all_r      <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= RESET_VEC;
            cp0_commit_r     <= 1'b0;
            busy_r           <= 1'b0;
            exc_cnt_r        <= 16'd0;
        end else begin
            cp0_commit_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r       <= ST_FLUSH;
                        flush_cnt_r   <= FLUSH_LOAD;
                        redirect_pc_r <= target_s;
                        cp0_commit_r  <= 1'b1;
                        flush_all_r   <= 1'b1;
                        busy_r        <= 1'b1;
                        if (exc_valid && (exc_cnt_r != 16'hFFFF)) begin
                            exc_cnt_r <= exc_cnt_r + 16'd1;
                        end else begin
                            exc_cnt_r <= exc_cnt_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r == 4'd0) begin
                        state_r          <= ST_REDIRECT;
                        flush_all_r      <= 1'b0;
                        redirect_valid_r <= 1'b1;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_r          <= ST_DRAIN;
                        redirect_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_REDIRECT;
                    end
                end
                // Inputs in DRAIN reflect stale WB state and are deliberately ignored.
                ST_DRAIN: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r          <= ST_IDLE;
                    flush_all_r      <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    busy_r           <= 1'b0;
                end
            endcase
        end
    end

    assign flush_all      = flush_all_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign cp0_commit     = cp0_commit_r;
    assign busy           = busy_r;
    assign exc_cnt        = exc_cnt_r;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: reset, exception/ERET sequences, stall, refill, async abort.
module tb_exc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_valid = 1'b0;
    logic        exc_is_eret = 1'b0;
    logic        exc_refill = 1'b0;
    logic [31:0] epc_in = 32'h0;
    logic        status_bev = 1'b0;
    logic        stall_w = 1'b0;
    logic        redirect_ready = 1'b0;
    logic        flush_all;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        cp0_commit;
    logic        busy;
    logic [15:0] exc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    exc_redirect_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exc_valid      (exc_valid),
        .exc_is_eret    (exc_is_eret),
        .exc_refill     (exc_refill),
        .epc_in         (epc_in),
        .status_bev     (status_bev),
        .stall_w        (stall_w),
        .redirect_ready (redirect_ready),
        .flush_all      (flush_all),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .cp0_commit     (cp0_commit),
        .busy           (busy),
        .exc_cnt        (exc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {flush_all, redirect_valid, cp0_commit, busy}
    function automatic logic [31:0] flags();
        return {28'd0, flush_all, redirect_valid, cp0_commit, busy};
    endfunction

    logic [31:0] refill_exp;

    initial begin
`ifdef TLB_REFILL_VEC_EN
        refill_exp = 32'h8000_0000;
`else
        refill_exp = 32'h8000_0180;
`endif
        // 1. reset release
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_flags", flags(), 32'h0);
        chk("rst_pc", redirect_pc, 32'hBFC0_0000);
        chk("rst_cnt", {16'd0, exc_cnt}, 32'd0);

        // 2. exception, bev=1, ready tied high
        exc_valid = 1'b1; status_bev = 1'b1; redirect_ready = 1'b1;
        step();
        exc_valid = 1'b0;
        chk("t2_accept_flags", flags(), 32'b1011);
        chk("t2_cnt", {16'd0, exc_cnt}, 32'd1);
        step();
        chk("t2_flush2_flags", flags(), 32'b1001);
        step();
        chk("t2_redirect_flags", flags(), 32'b0101);
        chk("t2_redirect_pc", redirect_pc, 32'hBFC0_0380);
        step();
        chk("t2_drain_flags", flags(), 32'b0001);
        chk("t2_pc_kept", redirect_pc, 32'hBFC0_0380);
        step();
        chk("t2_idle_flags", flags(), 32'b0000);

        // 3. ERET with fetch back-pressure
        exc_is_eret = 1'b1; epc_in = 32'h8000_1234; redirect_ready = 1'b0;
        step();
        exc_is_eret = 1'b0; epc_in = 32'h0;
        chk("t3_accept_flags", flags(), 32'b1011);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_flags", flags(), 32'b0101);
            chk("t3_hold_pc", redirect_pc, 32'h8000_1234);
            step();
        end
        redirect_ready = 1'b1;
        chk("t3_last_wait_valid", {31'd0, redirect_valid}, 32'd1);
        step();
        chk("t3_after_hs_flags", flags(), 32'b0001);
        step();
        chk("t3_idle_flags", flags(), 32'b0000);
        chk("t3_cnt", {16'd0, exc_cnt}, 32'd1);

        // 4. stall blocks acceptance; exc_valid held through sequence is ignored
        exc_valid = 1'b1; stall_w = 1'b1; status_bev = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stalled_flags", flags(), 32'b0000);
        end
        stall_w = 1'b0;
        step();
        chk("t4_accept_flags", flags(), 32'b1011);
        step();
        chk("t4_flush2_flags", flags(), 32'b1001);
        step();
        chk("t4_redirect_flags", flags(), 32'b0101);
        step();
        chk("t4_drain_flags", flags(), 32'b0001);
        exc_valid = 1'b0;
        step();
        chk("t4_idle_flags", flags(), 32'b0000);
        chk("t4_cnt", {16'd0, exc_cnt}, 32'd2);

        // exception and ERET together: exception wins (bev=0 general vector)
        exc_valid = 1'b1; exc_is_eret = 1'b1; epc_in = 32'h1111_2222; status_bev = 1'b0;
        step();
        exc_valid = 1'b0; exc_is_eret = 1'b0;
        step();
        step();
        chk("both_pc", redirect_pc, 32'h8000_0180);
        chk("both_cnt", {16'd0, exc_cnt}, 32'd3);
        step();
        step();

        // 5. TLB refill, bev=0
        exc_valid = 1'b1; exc_refill = 1'b1; status_bev = 1'b0;
        step();
        exc_valid = 1'b0; exc_refill = 1'b0;
        step();
        step();
        chk("t5_refill_pc", redirect_pc, refill_exp);
        chk("t5_cnt", {16'd0, exc_cnt}, 32'd4);
        step();
        step();

        // 6. async reset while in REDIRECT
        exc_valid = 1'b1; status_bev = 1'b1; redirect_ready = 1'b0;
        step();
        exc_valid = 1'b0;
        step();
        step();
        chk("t6_pre_valid", {31'd0, redirect_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_flags", flags(), 32'h0);
        chk("t6_async_pc", redirect_pc, 32'hBFC0_0000);
        chk("t6_async_cnt", {16'd0, exc_cnt}, 32'd0);
        step();
        rst = 1'b1;
        redirect_ready = 1'b1;
        step();
        chk("t6_post_rst_flags", flags(), 32'h0);

        // saturation: preload counter, then two exceptions
        force dut.exc_cnt_r = 16'hFFFE;
        #1;
        release dut.exc_cnt_r;
        chk("sat_preload", {16'd0, exc_cnt}, 32'h0000_FFFE);
        for (int k = 0; k < 2; k++) begin
            exc_valid = 1'b1;
            step();
            exc_valid = 1'b0;
            chk("sat_cnt", {16'd0, exc_cnt}, 32'h0000_FFFF);
            step();
            step();
            step();
            step();
        end
        chk("sat_final_flags", flags(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
